arith_arbiter: RTL and testbench

//  Shares one combinational 32-bit arithmetic unit (opcodes 000 add, 001 mul, 010 abs-diff, 011 div) between two requesters.

---
 rtl/arith_arbiter.sv | 92 +++++++++
 tb/tb_arith_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/arith_arbiter.sv
// arith_arbiter: round-robin arbiter sharing one multicycle arith unit between two requesters
// Ports: clk/rst (sync, active-high); req0/req1 valid-ready request channels carrying a, b, op;
// rsp0/rsp1 valid-ready result channels carrying data; au_a/au_b/au_opcode drive the shared unit
// and au_result returns its combinational result. Define ARITH_ARB_ERRFLAG_EN to add rsp0_err/rsp1_err.
module arith_arbiter #(
  parameter int DW = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_op,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_data,
`ifdef ARITH_ARB_ERRFLAG_EN
  output logic          rsp0_err,
  output logic          rsp1_err,
`endif
  output logic [DW-1:0] au_a,
  output logic [DW-1:0] au_b,
  output logic [2:0]    au_opcode,
  input  logic [DW-1:0] au_result
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  logic [1:0] state;
  logic [CW-1:0] cnt, hold;
  logic rr, gid, g, xfer, rsp_ack;
  logic [2:0] op_in;
  always_comb begin
    g = req0_valid && req1_valid ? rr : req1_valid;
    xfer = !rst && state == IDLE && (req0_valid || req1_valid);
    req0_ready = xfer && !g;
    req1_ready = xfer && g;
    op_in = g ? req1_op : req0_op;
    hold = op_in == 3'b001 ? CW'(MUL_CYCLES) : op_in == 3'b011 ? CW'(DIV_CYCLES) : CW'(1);
    rsp0_valid = state == RESP && !gid;
    rsp1_valid = state == RESP && gid;
    rsp_ack = gid ? rsp1_ready : rsp0_ready;
  end
`ifdef ARITH_ARB_ERRFLAG_EN
  // Latched operands stay stable through RESP, so the flag can be decoded from them directly.
  logic err;
  always_comb begin
    err = au_opcode[2] || (au_opcode == 3'b011 && au_b == '0);
    rsp0_err = rsp0_valid && err;
    rsp1_err = rsp1_valid && err;
  end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rr <= 1'b0;
      gid <= 1'b0;
      cnt <= '0;
      au_a <= '0;
      au_b <= '0;
      au_opcode <= 3'b000;
      rsp0_data <= '0;
      rsp1_data <= '0;
    end else if (state == IDLE) begin
      if (xfer) begin
        au_a <= g ? req1_a : req0_a;
        au_b <= g ? req1_b : req0_b;
        au_opcode <= op_in;
        gid <= g;
        rr <= !g;
        cnt <= hold;
        state <= EXEC;
      end
    end else if (state == EXEC) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        if (gid) rsp1_data <= au_result;
        else rsp0_data <= au_result;
        state <= RESP;
      end
    end else if (rsp_ack) state <= IDLE;
endmodule

// File: tb/tb_arith_arbiter.sv
// tb_arith_arbiter: randomized and directed self-checking bench for arith_arbiter
module tb_arith_arbiter;
  localparam int MC = 2, DC = 4;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0, au_opcode;
  logic [31:0] rsp0_data, rsp1_data, au_a, au_b, au_result;
`ifdef ARITH_ARB_ERRFLAG_EN
  logic rsp0_err, rsp1_err;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  arith_arbiter #(.DW(32), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
`ifdef ARITH_ARB_ERRFLAG_EN
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
    .au_a(au_a), .au_b(au_b), .au_opcode(au_opcode), .au_result(au_result)
  );
  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a * b;
      3'd2: return a > b ? a - b : b - a;
      3'd3: return b == 0 ? 32'h8000_0000 : a / b;
      default: return 32'd0;
    endcase
  endfunction
  always_comb au_result = alu(au_opcode, au_a, au_b);
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit r, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (r) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask
  task automatic do_op(input bit r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    int hold = op == 3'b001 ? MC : op == 3'b011 ? DC : 1;
    int t = 0;
    logic [31:0] exp = alu(op, a, b);
    @(negedge clk);
    drive(r, 1'b1, op, a, b);
    #1;
    while (!(r ? req1_ready : req0_ready) && t < 10) begin @(negedge clk); #1; t++; end
    chk("accept", t < 10, 1);
    chk("other_ready_idle", r ? req0_ready : req1_ready, 0);
    @(negedge clk);
    drive(r, 1'b0, 3'd0, $urandom, $urandom);
    drive(!r, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("exec_au_a", au_a, a);
      chk("exec_au_b", au_b, b);
      chk("exec_au_op", au_opcode, op);
      chk("exec_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("exec_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    for (int i = 0; i <= stall; i++) begin
      if (r) rsp1_ready = i == stall; else rsp0_ready = i == stall;
      if (r) req0_valid = i < stall; else req1_valid = i < stall;
      #1;
      chk("rsp_valid", r ? rsp1_valid : rsp0_valid, 1);
      chk("rsp_other_valid", r ? rsp0_valid : rsp1_valid, 0);
      chk("rsp_data", r ? rsp1_data : rsp0_data, exp);
      chk("resp_ready", {req0_ready, req1_ready}, 0);
      chk("resp_au_op", au_opcode, op);
`ifdef ARITH_ARB_ERRFLAG_EN
      chk("rsp_err", r ? rsp1_err : rsp0_err, (op == 3'b011 && b == 0) || op[2]);
`endif
      @(negedge clk);
    end
    rsp0_ready = 0;
    rsp1_ready = 0;
    #1;
    chk("rsp_drop", {rsp0_valid, rsp1_valid}, 0);
  endtask
  // Both requesters always valid: grants must alternate starting from requester 0, one every 3 cycles.
  task automatic alternation();
    int grants = 0, t = 0, last_t = -1;
    bit exp_g = 0;
    @(negedge clk);
    drive(0, 1'b1, 3'd0, $urandom, $urandom);
    drive(1, 1'b1, 3'd0, $urandom, $urandom);
    rsp0_ready = 1;
    rsp1_ready = 1;
    while (grants < 6 && t < 100) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("grant_both", req0_ready && req1_ready, 0);
        chk("grant_order", req1_ready, exp_g);
        if (last_t >= 0) chk("grant_spacing", t - last_t, 3);
        last_t = t;
        exp_g = !exp_g;
        grants++;
      end
      @(negedge clk);
      t++;
    end
    chk("grant_count", grants, 6);
    req0_valid = 0;
    req1_valid = 0;
    repeat (4) @(negedge clk);
    rsp0_ready = 0;
    rsp1_ready = 0;
  endtask
  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_au_a", au_a, 0);
    chk("rst_au_op", au_opcode, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    rst = 0;
    alternation();
    do_op(0, 3'b000, 32'd5, 32'd7, 0);
    do_op(0, 3'b001, 32'd6, 32'd7, 5);
    do_op(1, 3'b011, 32'd100, 32'd7, 0);
    do_op(1, 3'b011, 32'd9, 32'd0, 1);
    do_op(0, 3'b101, 32'd3, 32'd4, 0);
    do_op(0, 3'b010, 32'd3, 32'd10, 2);
    for (int k = 0; k < 16; k++) begin
      logic [2:0] op = 3'($urandom_range(0, 7));
      logic [31:0] b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
      do_op(1'($urandom_range(0, 1)), op, $urandom, b, $urandom_range(0, 3));
    end
    do_op(1, 3'b000, 32'd3, 32'd4, 0);
    do_op(0, 3'b000, 32'd1, 32'd2, 0);
    @(negedge clk);
    drive(0, 1'b1, 3'b011, 32'd50, 32'd5);
    #1;
    chk("div_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("post_rst_au_a", au_a, 0);
    chk("post_rst_au_b", au_b, 0);
    chk("post_rst_au_op", au_opcode, 0);
    chk("post_rst_rsp0_data", rsp0_data, 0);
    chk("post_rst_rsp1_data", rsp1_data, 0);
    chk("post_rst_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("post_rst_ready", {req0_ready, req1_ready}, 0);
    seen = 0;
    repeat (10) begin @(negedge clk); #1; seen |= rsp0_valid; end
    chk("no_rsp_after_rst", seen, 0);
    alternation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
